// File: rtl/fc_layer_sequencer.sv
// Control sequencer for one fully-connected layer: walks neurons and input chunks,
// drives memory/ALU strobes and hands results out. Define FC_RELU_EN to clamp negative results.
module fc_layer_sequencer #(
    parameter int SIZE     = 16,
    parameter int INPUT_SZ = 4,
    parameter int ADDR_W   = 10,
    parameter int NEUR_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_num_inputs,
    input  logic [NEUR_W-1:0]   cfg_num_neurons,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [NEUR_W-1:0]   rd_neuron,
    output logic [INPUT_SZ-1:0] lane_mask,
    output logic                alu_clear,
    output logic                alu_enable,
    input  logic [SIZE-1:0]     alu_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZE-1:0]     out_data,
    output logic [NEUR_W-1:0]   out_index
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        ACC,
        EMIT,
        FINISH
    } state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   num_inputs_q;
    logic [NEUR_W-1:0]   num_neurons_q;
    logic [ADDR_W-1:0]   last_chunk_q;
    logic [ADDR_W-1:0]   rem_lanes_q;
    logic [ADDR_W-1:0]   chunk_cnt;
    logic [NEUR_W-1:0]   neuron_cnt;
    logic                is_last_chunk;
    logic                is_last_neuron;
    logic [INPUT_SZ-1:0] partial_mask;

    assign is_last_chunk  = (chunk_cnt == last_chunk_q);
    assign is_last_neuron = (neuron_cnt == num_neurons_q - NEUR_W'(1));

    // Low rem_lanes_q lanes are live in the final chunk of a non-multiple input count.
    always_comb begin
        partial_mask = '0;
        for (int i = 0; i < INPUT_SZ; i++) begin
            partial_mask[i] = (ADDR_W'(i) < rem_lanes_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        rd_en      = 1'b0;
        alu_clear  = 1'b0;
        alu_enable = 1'b0;
        out_valid  = 1'b0;
        lane_mask  = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = (cfg_num_neurons == '0) ? FINISH : CLEAR;
                end
            end
            CLEAR: begin
                alu_clear  = 1'b1;
                next_state = (num_inputs_q == '0) ? EMIT : FETCH;
            end
            FETCH: begin
                rd_en      = 1'b1;
                next_state = ACC;
            end
            ACC: begin
                alu_enable = 1'b1;
                lane_mask  = (is_last_chunk && rem_lanes_q != '0) ? partial_mask : '1;
                next_state = is_last_chunk ? EMIT : FETCH;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = is_last_neuron ? FINISH : CLEAR;
                end
            end
            FINISH: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                busy       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    assign rd_addr   = chunk_cnt;
    assign rd_neuron = neuron_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_inputs_q  <= '0;
            num_neurons_q <= '0;
            last_chunk_q  <= '0;
            rem_lanes_q   <= '0;
            chunk_cnt     <= '0;
            neuron_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_inputs_q  <= cfg_num_inputs;
                        num_neurons_q <= cfg_num_neurons;
                        // Only meaningful when cfg_num_inputs is non-zero; CLEAR bypasses chunks otherwise.
                        last_chunk_q  <= ADDR_W'((cfg_num_inputs - ADDR_W'(1)) / INPUT_SZ);
                        rem_lanes_q   <= ADDR_W'(cfg_num_inputs % INPUT_SZ);
                        chunk_cnt     <= '0;
                        neuron_cnt    <= '0;
                    end
                end
                CLEAR: chunk_cnt <= '0;
                ACC: begin
                    if (!is_last_chunk) begin
                        chunk_cnt <= chunk_cnt + ADDR_W'(1);
                    end
                end
                EMIT: begin
                    if (out_ready && !is_last_neuron) begin
                        neuron_cnt <= neuron_cnt + NEUR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result is captured once on EMIT entry and then held for the whole handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_index <= '0;
        end else if (next_state == EMIT && state != EMIT) begin
`ifdef FC_RELU_EN
            out_data  <= alu_value[SIZE-1] ? '0 : alu_value;
`else
            out_data  <= alu_value;
`endif
            out_index <= neuron_cnt;
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: table of layer shapes plus stall, ignored-start and reset sequences,
// with a scoreboard of expected neuron results.
module tb_fc_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  cfg_num_inputs = '0;
    logic [7:0]  cfg_num_neurons = '0;
    logic        busy, done, rd_en, alu_clear, alu_enable, out_valid;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_neuron, out_index;
    logic [3:0]  lane_mask;
    logic [15:0] alu_value = '0;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;

    fc_layer_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_num_inputs(cfg_num_inputs), .cfg_num_neurons(cfg_num_neurons),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_neuron(rd_neuron), .lane_mask(lane_mask), .alu_clear(alu_clear),
        .alu_enable(alu_enable), .alu_value(alu_value), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_index(out_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  idx;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        int         ni;
        int         nn;
        int         exp_first;
        int         exp_done;
        logic [3:0] exp_last_mask;
    } vec_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          val_idx = 0;
    logic [15:0] vals [6] = '{16'hFF00, 16'h0100, 16'h8001, 16'h7FFF, 16'h1234, 16'hABCD};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef FC_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [3:0] exp_mask(input int ni, input int chunk);
        int c;
        int rem;
        c   = (ni + 3) / 4;
        rem = ni % 4;
        if (chunk == c - 1 && rem != 0) return 4'((1 << rem) - 1);
        return 4'hF;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_rd_neuron"}, rd_neuron, 0);
        check({tag, "_lane_mask"}, lane_mask, 0);
        check({tag, "_alu_clear"}, alu_clear, 0);
        check({tag, "_alu_enable"}, alu_enable, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_index"}, out_index, 0);
    endtask

    // One full layer with per-cycle protocol tracking; stall_n < 0 means no back-pressure.
    task automatic run_layer(input vec_t v, input int stall_n, input int stall_len, input bit poke);
        int cyc, first_v, done_cyc, act, exp_act, chunk, neur, stalled;
        int bad_excl, bad_rd, bad_mask, bad_busy;
        logic [15:0] held_d;
        logic [7:0]  held_i;
        logic [3:0]  last_mask;
        bit          finished;
        exp_t        e;
        first_v = 0; done_cyc = 0; act = 0; chunk = 0; neur = 0; stalled = 0;
        bad_excl = 0; bad_rd = 0; bad_mask = 0; bad_busy = 0;
        last_mask = '0; finished = 0; held_d = '0; held_i = '0;
        exp_act = v.nn * (1 + 2 * ((v.ni + 3) / 4));
        @(negedge clk);
        cfg_num_inputs  = 10'(v.ni);
        cfg_num_neurons = 8'(v.nn);
        start = 1'b1;
        out_ready = 1'b1;
        for (cyc = 1; cyc <= 300 && !finished; cyc++) begin
            @(negedge clk);
            start = poke && cyc == 3;
            if (poke && cyc == 3) begin
                cfg_num_inputs  = 10'd1;
                cfg_num_neurons = 8'd5;
            end
            if (!busy) bad_busy++;
            if (int'(rd_en) + int'(alu_clear) + int'(alu_enable) > 1) bad_excl++;
            if (rd_en || alu_clear || alu_enable) act++;
            if (alu_clear) begin
                chunk = 0;
                alu_value = vals[val_idx % 6];
                val_idx++;
                e.idx  = 8'(neur);
                e.data = relu(alu_value);
                sb.push_back(e);
            end
            if (rd_en && (rd_addr !== 10'(chunk) || rd_neuron !== 8'(neur))) bad_rd++;
            if (alu_enable) begin
                if (lane_mask !== exp_mask(v.ni, chunk)) bad_mask++;
                last_mask = lane_mask;
                chunk++;
            end
            if (out_valid) begin
                if (first_v == 0) first_v = cyc;
                if (neur == stall_n && stalled < stall_len) begin
                    if (stalled == 0) begin
                        held_d = out_data;
                        held_i = out_index;
                    end else begin
                        check("stall_data", out_data, held_d);
                        check("stall_index", out_index, held_i);
                    end
                    stalled++;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    check("sb_has_entry", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("out_index", out_index, e.idx);
                        check("out_data", out_data, e.data);
                    end
                    neur++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done) begin
                done_cyc = cyc;
                finished = 1;
            end
        end
        check("layer_finished", finished, 1);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("first_valid_cycle", first_v, v.exp_first);
        check("done_cycle", done_cyc, v.exp_done);
        check("last_lane_mask", last_mask, v.exp_last_mask);
        check("strobe_cycles", act, exp_act);
        check("strobe_overlap", bad_excl, 0);
        check("rd_addr_neuron", bad_rd, 0);
        check("lane_masks", bad_mask, 0);
        check("busy_while_active", bad_busy, 0);
        check("neurons_emitted", neur, v.nn);
        check("sb_drained", sb.size(), 0);
    endtask

    vec_t vecs[$];
    vec_t stall_vec;

    initial begin
        int   neur;
        int   n_done;
        bit   hit;
        vecs.push_back('{8, 1, 6, 7, 4'b1111});
        vecs.push_back('{6, 1, 6, 7, 4'b0011});
        vecs.push_back('{0, 2, 2, 5, 4'b0000});
        vecs.push_back('{5, 0, 0, 1, 4'b0000});
        vecs.push_back('{1, 2, 4, 9, 4'b0001});
        vecs.push_back('{4, 1, 4, 5, 4'b1111});
        vecs.push_back('{13, 2, 10, 21, 4'b0001});

        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        foreach (vecs[i]) run_layer(vecs[i], -1, 0, 1'b0);

        // Three neurons, back-pressure on neuron 1, and a start pulse while busy.
        stall_vec = '{5, 3, 6, 24, 4'b0001};
        run_layer(stall_vec, 1, 5, 1'b1);

        // Reset during ACC of neuron 1 abandons the layer without a done pulse.
        @(negedge clk);
        cfg_num_inputs  = 10'd8;
        cfg_num_neurons = 8'd3;
        start = 1'b1;
        out_ready = 1'b1;
        neur = 0;
        hit = 0;
        n_done = 0;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) n_done++;
            if (out_valid) neur++;
            if (alu_enable && neur == 1) begin
                rst_n = 1'b0;
                hit = 1;
            end
        end
        check("reached_acc_n1", hit, 1);
        #1;
        check_all_zero("midreset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("no_done_after_abort", n_done, 0);
        sb.delete();
        run_layer(vecs[0], -1, 0, 1'b0);
        run_layer('{6, 2, 6, 13, 4'b0011}, -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
